// File: rtl/lsu_mem_access.sv
// lsu_mem_access: load/store unit memory-access sequencer.
//   Accepts one op at a time from the LSU front end (lsu_valid_i/lsu_ready_o),
//   checks size/alignment, issues one request on a req/gnt + rvalid bus, and
//   returns a one-cycle writeback pulse (lsu_wb_*_o) with the loaded,
//   extended data, the pass-through address for non-memory ops, or an error.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   lsu_*_i / lsu_ready_o       upstream op handshake and operands
//   lsu_wb_*_o, lsu_err_o       writeback result, valid exactly in DONE
//   mem_*_o / mem_*_i           memory bus request and response
module lsu_mem_access (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic        lsu_re_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_size_i,
    input  logic        lsu_unsigned_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        lsu_rd_wen_i,
    output logic        lsu_wb_valid_o,
    output logic [31:0] lsu_wb_data_o,
    output logic        lsu_wb_wen_o,
    output logic        lsu_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wmask_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, nxt;
    logic        rdy_q;
    logic        we_q, uns_q, rd_wen_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wmask_q;
    logic [31:0] wb_data_q, wb_data_nxt;
    logic        wb_wen_q, wb_wen_nxt, err_q, err_nxt;
    logic        accept, is_mem, bad;

    // Shift the addressed byte lane down to bit 0, then extend to 32 bits.
    function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [1:0] a,
                                             input logic [1:0] sz, input logic u);
        logic [31:0] s;
        s = rd >> {a, 3'b000};
        case (sz)
            2'b00:   load_ext = u ? {24'b0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
            2'b01:   load_ext = u ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: load_ext = s;
        endcase
    endfunction

    assign accept = lsu_valid_i && lsu_ready_o;
    assign is_mem = lsu_re_i || lsu_we_i;
    // Size/alignment only matter for ops that touch memory; a plain
    // pass-through op never errors.
    assign bad = (lsu_re_i && lsu_we_i) || (lsu_size_i == 2'b11) ||
                 (lsu_size_i == 2'b01 && lsu_addr_i[0]) ||
                 (lsu_size_i == 2'b10 && lsu_addr_i[1:0] != 2'b00);

    // rdy_q keeps ready low during reset and lifts it on the first edge after release.
    assign lsu_ready_o    = rdy_q && (state == IDLE);
    assign lsu_wb_valid_o = (state == DONE);
    assign lsu_wb_data_o  = wb_data_q;
    assign lsu_wb_wen_o   = wb_wen_q;
    assign lsu_err_o      = err_q;
    assign mem_req_o      = (state == REQ);
    assign mem_we_o       = we_q;
    assign mem_addr_o     = {addr_q[31:2], 2'b00};
    assign mem_wdata_o    = wdata_q;
    assign mem_wmask_o    = wmask_q;

    // Next state plus the writeback value to latch on the edge entering DONE;
    // the *_nxt values are zero on every other transition so the registered
    // outputs read 0 outside DONE.
    always_comb begin
        nxt         = state;
        wb_data_nxt = '0;
        wb_wen_nxt  = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (!is_mem) begin
                    nxt         = DONE;
                    wb_data_nxt = lsu_addr_i;
                    wb_wen_nxt  = lsu_rd_wen_i;
                end else if (bad) begin
                    nxt     = DONE;
                    err_nxt = 1'b1;
                end else begin
                    nxt = REQ;
                end
            end
            REQ: if (mem_gnt_i) begin
                nxt = mem_rvalid_i ? DONE : WAIT;
            end
            WAIT: if (mem_rvalid_i) nxt = DONE;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
        // Bus completion: stores return nothing, loads return extended data.
        if ((state == REQ || state == WAIT) && nxt == DONE && !we_q) begin
            wb_data_nxt = load_ext(mem_rdata_i, addr_q[1:0], size_q, uns_q);
            wb_wen_nxt  = rd_wen_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rdy_q     <= 1'b0;
            wb_data_q <= '0;
            wb_wen_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= nxt;
            rdy_q     <= 1'b1;
            wb_data_q <= wb_data_nxt;
            wb_wen_q  <= wb_wen_nxt;
            err_q     <= err_nxt;
        end
    end

    // Operand capture at acceptance; bus fields stay frozen until the next op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            rd_wen_q <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= 4'b0000;
        end else if (accept) begin
            we_q     <= lsu_we_i;
            uns_q    <= lsu_unsigned_i;
            rd_wen_q <= lsu_rd_wen_i;
            size_q   <= lsu_size_i;
            addr_q   <= lsu_addr_i;
            if (lsu_we_i) begin
                case (lsu_size_i)
                    2'b00:   begin wmask_q <= 4'b0001 << lsu_addr_i[1:0]; wdata_q <= {4{lsu_wdata_i[7:0]}};  end
                    2'b01:   begin wmask_q <= 4'b0011 << lsu_addr_i[1:0]; wdata_q <= {2{lsu_wdata_i[15:0]}}; end
                    default: begin wmask_q <= 4'b1111;                    wdata_q <= lsu_wdata_i;            end
                endcase
            end else begin
                wmask_q <= 4'b1111;
                wdata_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_access.sv
module tb_lsu_mem_access;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_valid_i = 1'b0, lsu_ready_o;
    logic        lsu_re_i = 1'b0, lsu_we_i = 1'b0, lsu_unsigned_i = 1'b0, lsu_rd_wen_i = 1'b0;
    logic [1:0]  lsu_size_i = 2'b00;
    logic [31:0] lsu_addr_i = '0, lsu_wdata_i = '0;
    logic        lsu_wb_valid_o, lsu_wb_wen_o, lsu_err_o;
    logic [31:0] lsu_wb_data_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lsu_mem_access dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .lsu_re_i(lsu_re_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
        .lsu_unsigned_i(lsu_unsigned_i), .lsu_addr_i(lsu_addr_i),
        .lsu_wdata_i(lsu_wdata_i), .lsu_rd_wen_i(lsu_rd_wen_i),
        .lsu_wb_valid_o(lsu_wb_valid_o), .lsu_wb_data_o(lsu_wb_data_o),
        .lsu_wb_wen_o(lsu_wb_wen_o), .lsu_err_o(lsu_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct {
        logic        re, we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr, wdata;
        logic        rd_wen;
        int          gdly;     // cycles in REQ before gnt
        logic        same;     // rvalid together with gnt
        logic [31:0] rdata;
        logic        mem;      // expects a bus request
        logic [31:0] maddr;
        logic [3:0]  mask;
        logic [31:0] mwdata;
        logic [31:0] data;
        logic        wen, err;
    } vec_t;

    vec_t v[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t t;
        t = v[i];
        @(negedge clk);
        chk($sformatf("v%0d ready", i), {31'b0, lsu_ready_o}, 32'd1);
        lsu_valid_i = 1'b1; lsu_re_i = t.re; lsu_we_i = t.we; lsu_size_i = t.size;
        lsu_unsigned_i = t.uns; lsu_addr_i = t.addr; lsu_wdata_i = t.wdata; lsu_rd_wen_i = t.rd_wen;
        @(negedge clk);
        lsu_valid_i = 1'b0;
        if (t.mem) begin
            // Stray rvalid without gnt must be ignored while in REQ.
            for (int d = 0; d < t.gdly; d++) begin
                chk($sformatf("v%0d req hold", i), {31'b0, mem_req_o}, 32'd1);
                chk($sformatf("v%0d addr hold", i), mem_addr_o, t.maddr);
                chk($sformatf("v%0d wdata hold", i), mem_wdata_o, t.mwdata);
                mem_rvalid_i = 1'b1;
                @(negedge clk);
                mem_rvalid_i = 1'b0;
            end
            chk($sformatf("v%0d req", i), {31'b0, mem_req_o}, 32'd1);
            chk($sformatf("v%0d maddr", i), mem_addr_o, t.maddr);
            chk($sformatf("v%0d mwe", i), {31'b0, mem_we_o}, {31'b0, t.we});
            chk($sformatf("v%0d mask", i), {28'b0, mem_wmask_o}, {28'b0, t.mask});
            chk($sformatf("v%0d mwdata", i), mem_wdata_o, t.mwdata);
            mem_gnt_i = 1'b1; mem_rvalid_i = t.same; mem_rdata_i = t.rdata;
            @(negedge clk);
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
            if (!t.same) begin
                chk($sformatf("v%0d wait noreq", i), {31'b0, mem_req_o}, 32'd0);
                chk($sformatf("v%0d wait nowb", i), {31'b0, lsu_wb_valid_o}, 32'd0);
                mem_rvalid_i = 1'b1; mem_rdata_i = t.rdata;
                @(negedge clk);
                mem_rvalid_i = 1'b0; mem_rdata_i = '0;
            end
        end else begin
            chk($sformatf("v%0d noreq", i), {31'b0, mem_req_o}, 32'd0);
        end
        chk($sformatf("v%0d wb_valid", i), {31'b0, lsu_wb_valid_o}, 32'd1);
        chk($sformatf("v%0d wb_data", i), lsu_wb_data_o, t.data);
        chk($sformatf("v%0d wb_wen", i), {31'b0, lsu_wb_wen_o}, {31'b0, t.wen});
        chk($sformatf("v%0d err", i), {31'b0, lsu_err_o}, {31'b0, t.err});
        chk($sformatf("v%0d done busy", i), {31'b0, lsu_ready_o}, 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d wb drop", i), {31'b0, lsu_wb_valid_o}, 32'd0);
        chk($sformatf("v%0d data clr", i), lsu_wb_data_o, 32'd0);
    endtask

    initial begin
        //        re   we   sz    u    addr          wdata         rw  gd same rdata         mem  maddr         mask     mwdata        data          wen  err
        v[0]  = '{1'b0,1'b0,2'b10,1'b0,32'h0000_1234,32'h0,        1'b1,0,1'b0,32'h0,        1'b0,32'h0,        4'h0,    32'h0,        32'h0000_1234,1'b1,1'b0};
        v[1]  = '{1'b1,1'b0,2'b00,1'b0,32'h0000_1003,32'h0,        1'b1,0,1'b0,32'h80AA_BBCC,1'b1,32'h0000_1000,4'b1111, 32'h0,        32'hFFFF_FF80,1'b1,1'b0};
        v[2]  = '{1'b0,1'b1,2'b01,1'b0,32'h0000_2002,32'h0000_BEEF,1'b1,3,1'b0,32'h0,        1'b1,32'h0000_2000,4'b1100, 32'hBEEF_BEEF,32'h0,        1'b0,1'b0};
        v[3]  = '{1'b1,1'b0,2'b10,1'b0,32'h0000_3001,32'h0,        1'b1,0,1'b0,32'h0,        1'b0,32'h0,        4'h0,    32'h0,        32'h0,        1'b0,1'b1};
        v[4]  = '{1'b1,1'b0,2'b01,1'b1,32'h0000_4002,32'h0,        1'b1,0,1'b1,32'hFFEE_0011,1'b1,32'h0000_4000,4'b1111, 32'h0,        32'h0000_FFEE,1'b1,1'b0};
        v[5]  = '{1'b1,1'b0,2'b10,1'b0,32'h0000_5000,32'h0,        1'b1,1,1'b0,32'h1234_5678,1'b1,32'h0000_5000,4'b1111, 32'h0,        32'h1234_5678,1'b1,1'b0};
        v[6]  = '{1'b1,1'b0,2'b01,1'b0,32'h0000_6000,32'h0,        1'b1,0,1'b0,32'h0000_8001,1'b1,32'h0000_6000,4'b1111, 32'h0,        32'hFFFF_8001,1'b1,1'b0};
        v[7]  = '{1'b1,1'b0,2'b00,1'b1,32'h0000_7001,32'h0,        1'b0,0,1'b1,32'h0000_AB00,1'b1,32'h0000_7000,4'b1111, 32'h0,        32'h0000_00AB,1'b0,1'b0};
        v[8]  = '{1'b0,1'b1,2'b00,1'b0,32'h0000_8001,32'h1234_56A5,1'b1,1,1'b0,32'h0,        1'b1,32'h0000_8000,4'b0010, 32'hA5A5_A5A5,32'h0,        1'b0,1'b0};
        v[9]  = '{1'b0,1'b1,2'b10,1'b0,32'h0000_9000,32'hDEAD_BEEF,1'b1,0,1'b1,32'h0,        1'b1,32'h0000_9000,4'b1111, 32'hDEAD_BEEF,32'h0,        1'b0,1'b0};
        v[10] = '{1'b1,1'b1,2'b10,1'b0,32'h0000_A000,32'h0,        1'b1,0,1'b0,32'h0,        1'b0,32'h0,        4'h0,    32'h0,        32'h0,        1'b0,1'b1};
        v[11] = '{1'b1,1'b0,2'b11,1'b0,32'h0000_B000,32'h0,        1'b1,0,1'b0,32'h0,        1'b0,32'h0,        4'h0,    32'h0,        32'h0,        1'b0,1'b1};
        v[12] = '{1'b0,1'b1,2'b01,1'b0,32'h0000_C001,32'h0,        1'b1,0,1'b0,32'h0,        1'b0,32'h0,        4'h0,    32'h0,        32'h0,        1'b0,1'b1};
        v[13] = '{1'b0,1'b0,2'b00,1'b0,32'hCAFE_F00D,32'h0,        1'b0,0,1'b0,32'h0,        1'b0,32'h0,        4'h0,    32'h0,        32'hCAFE_F00D,1'b0,1'b0};

        // Reset state.
        #12;
        chk("rst ready", {31'b0, lsu_ready_o}, 32'd0);
        chk("rst wb_valid", {31'b0, lsu_wb_valid_o}, 32'd0);
        chk("rst req", {31'b0, mem_req_o}, 32'd0);
        chk("rst addr", mem_addr_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("release ready low", {31'b0, lsu_ready_o}, 32'd0);
        @(negedge clk);
        chk("release ready high", {31'b0, lsu_ready_o}, 32'd1);

        // Bus responses while idle are ignored.
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        chk("idle rvalid ignored", {31'b0, lsu_wb_valid_o}, 32'd0);

        for (int i = 0; i < 14; i++) run_vec(i);

        // Reset while in WAIT, then a late rvalid after release.
        @(negedge clk);
        lsu_valid_i = 1'b1; lsu_re_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'b10;
        lsu_addr_i = 32'h0000_D004; lsu_rd_wen_i = 1'b1;
        @(negedge clk);
        lsu_valid_i = 1'b0;
        chk("wr req", {31'b0, mem_req_o}, 32'd1);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        chk("wr in wait", {31'b0, mem_req_o}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("wr rst ready", {31'b0, lsu_ready_o}, 32'd0);
        chk("wr rst addr", mem_addr_o, 32'd0);
        chk("wr rst wb", {31'b0, lsu_wb_valid_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_5555;
        @(negedge clk);
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        chk("late rvalid nowb", {31'b0, lsu_wb_valid_o}, 32'd0);
        chk("late rvalid ready", {31'b0, lsu_ready_o}, 32'd1);
        @(negedge clk);
        chk("late rvalid nowb2", {31'b0, lsu_wb_valid_o}, 32'd0);
        run_vec(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
